// File: rtl/keyed_access_ctrl.sv
// keyed_access_ctrl: serial-key unlock followed by a one-command-at-a-time flow sequencer.
// Optional macro LOCKOUT_EN: lock the key decoder after MAX_FAIL consecutive key mismatches.
//
// Key decoder
//   state      | meaning
//   KS_KEY     | collecting key bits, keyIdx = next bit to compare
//   KS_MODESEL | key matched, next ValidCmd selects Mode
//   KS_ACTIVE  | unlocked, sticky until Reset
// Flow FSM
//   state      | meaning
//   FS_IDLE    | waiting for a command (only while unlocked)
//   FS_RD_MEM  | memory read strobe
//   FS_WR_MEM  | memory write strobe
//   FS_SAMPLE  | operand/result sampling
//   FS_TX      | transfer running, waits for TransferDone or timeout

module keyed_access_ctrl #(
    parameter int                 KEY_LEN     = 4,
    parameter logic [KEY_LEN-1:0] KEY_PATTERN = 4'b0101,
    parameter int                 TIMEOUT     = 255,
    parameter int                 MAX_FAIL    = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ValidCmd,
    input  logic InputKey,
    input  logic RW,
    input  logic TransferDone,
    output logic Active,
    output logic Mode,
    output logic Busy,
    output logic AccessMem,
    output logic RWMem,
    output logic SampleData,
    output logic TransferData,
    output logic KeyError,
    output logic TxTimeout,
    output logic KeyLocked
);

    localparam int IW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(KEY_LEN - 1);
    localparam logic [CW-1:0] TX_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    generate
        if (KEY_LEN < 1 || MAX_FAIL < 1) begin : gBadParams
            $error("keyed_access_ctrl: KEY_LEN and MAX_FAIL must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        KS_KEY,
        KS_MODESEL,
        KS_ACTIVE
    } keyState_t;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_RD_MEM,
        FS_WR_MEM,
        FS_SAMPLE,
        FS_TX
    } flowState_t;

    keyState_t       keyState, keyNxt;
    logic [IW-1:0]   keyIdx, idxNxt;
    logic            modeReg, modeNxt;
    logic            keyErrReg, keyErrNxt;
    logic            keyLockedInt;
    logic            decodeEn;

    flowState_t      flowState, flowNxt;
    logic [CW-1:0]   txCnt, txCntNxt;
    logic            txToReg, txToNxt;

`ifdef LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic [FW-1:0]   failCnt, failCntNxt;
    logic            lockReg, lockNxt;

    assign keyLockedInt = lockReg;
`else
    assign keyLockedInt = 1'b0;
`endif

    // A locked decoder behaves as if ValidCmd never arrives.
    assign decodeEn = ValidCmd & ~keyLockedInt;

    always_comb begin
        keyNxt    = keyState;
        idxNxt    = keyIdx;
        modeNxt   = modeReg;
        keyErrNxt = 1'b0;
`ifdef LOCKOUT_EN
        failCntNxt = failCnt;
        lockNxt    = lockReg;
`endif
        case (keyState)
            KS_KEY: begin
                if (decodeEn) begin
                    if (InputKey == KEY_PATTERN[keyIdx]) begin
                        if (keyIdx == IDX_LAST) begin
                            keyNxt = KS_MODESEL;
                            idxNxt = '0;
`ifdef LOCKOUT_EN
                            failCntNxt = '0;
`endif
                        end else begin
                            idxNxt = keyIdx + IW'(1);
                        end
                    end else begin
                        idxNxt    = '0;
                        keyErrNxt = 1'b1;
`ifdef LOCKOUT_EN
                        failCntNxt = failCnt + FW'(1);
                        if (failCnt == FW'(MAX_FAIL - 1)) lockNxt = 1'b1;
`endif
                    end
                end
            end
            KS_MODESEL: begin
                if (decodeEn) begin
                    modeNxt = InputKey;
                    keyNxt  = KS_ACTIVE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        flowNxt  = flowState;
        txCntNxt = txCnt;
        txToNxt  = 1'b0;
        case (flowState)
            FS_IDLE: begin
                if (ValidCmd && keyState == KS_ACTIVE) begin
                    if (modeReg) flowNxt = RW ? FS_WR_MEM : FS_RD_MEM;
                    else         flowNxt = FS_SAMPLE;
                end
            end
            FS_RD_MEM: flowNxt = FS_SAMPLE;
            FS_WR_MEM: flowNxt = FS_IDLE;
            FS_SAMPLE: flowNxt = FS_TX;
            FS_TX: begin
                // TransferDone is checked before the timeout so a late completion still wins.
                if (TransferDone) begin
                    flowNxt  = FS_IDLE;
                    txCntNxt = '0;
                end else if (TIMEOUT != 0 && txCnt == TX_LAST) begin
                    flowNxt  = FS_IDLE;
                    txCntNxt = '0;
                    txToNxt  = 1'b1;
                end else if (txCnt != '1) begin
                    txCntNxt = txCnt + CW'(1);
                end
            end
            default: flowNxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keyState  <= KS_KEY;
            keyIdx    <= '0;
            modeReg   <= 1'b0;
            keyErrReg <= 1'b0;
            flowState <= FS_IDLE;
            txCnt     <= '0;
            txToReg   <= 1'b0;
`ifdef LOCKOUT_EN
            failCnt   <= '0;
            lockReg   <= 1'b0;
`endif
        end else begin
            keyState  <= keyNxt;
            keyIdx    <= idxNxt;
            modeReg   <= modeNxt;
            keyErrReg <= keyErrNxt;
            flowState <= flowNxt;
            txCnt     <= txCntNxt;
            txToReg   <= txToNxt;
`ifdef LOCKOUT_EN
            failCnt   <= failCntNxt;
            lockReg   <= lockNxt;
`endif
        end
    end

    assign Active       = (keyState == KS_ACTIVE);
    assign Mode         = modeReg;
    assign Busy         = (flowState != FS_IDLE);
    assign AccessMem    = (flowState == FS_RD_MEM) || (flowState == FS_WR_MEM);
    assign RWMem        = (flowState == FS_WR_MEM);
    assign SampleData   = (flowState == FS_SAMPLE);
    assign TransferData = (flowState == FS_TX);
    assign KeyError     = keyErrReg;
    assign TxTimeout    = txToReg;
    assign KeyLocked    = keyLockedInt;

endmodule
